// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS checker and generator.
//   - mode encodings (PRBS7/15/23/31)
//   - tap table of (A,B) pairs for b[n] = b[n-A] ^ b[n-B]
//   - checker FSM state type
//   - search_words(): ceil(A/width), the words needed to fill the history
package prbs_pkg;

  localparam logic [1:0] MODE_PRBS7  = 2'd0;
  localparam logic [1:0] MODE_PRBS15 = 2'd1;
  localparam logic [1:0] MODE_PRBS23 = 2'd2;
  localparam logic [1:0] MODE_PRBS31 = 2'd3;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
  } taps_t;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  function automatic taps_t prbs_taps(input logic [1:0] mode);
    taps_t t;
    t = '{a: 6'd7, b: 6'd6};
    case (mode)
      MODE_PRBS7:  t = '{a: 6'd7,  b: 6'd6};
      MODE_PRBS15: t = '{a: 6'd15, b: 6'd14};
      MODE_PRBS23: t = '{a: 6'd23, b: 6'd18};
      MODE_PRBS31: t = '{a: 6'd31, b: 6'd28};
      default:     t = '{a: 6'd7,  b: 6'd6};
    endcase
    return t;
  endfunction

  function automatic int unsigned search_words(input logic [1:0] mode,
                                               input int unsigned width);
    taps_t       t;
    int unsigned a;
    t = prbs_taps(mode);
    a = 32'(t.a);
    return (a + width - 1) / width;
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// prbs_predict: combinational PRBS word predictor.
// Ports:
//   history [30:0]        last 31 stream bits, history[30] is the newest
//   mode    [1:0]         polynomial select (see prbs_pkg)
//   next    [WORDWIDTH-1] next WORDWIDTH stream bits, bit 0 earliest
// Bits within the word feed later bits of the same word, so any width
// from 8 to 64 works for every polynomial.
module prbs_predict
  import prbs_pkg::*;
#(
  parameter int unsigned WORDWIDTH = 32
) (
  input  logic [30:0]          history,
  input  logic [1:0]           mode,
  output logic [WORDWIDTH-1:0] next
);

  function automatic logic [WORDWIDTH-1:0] unroll(input logic [30:0] h,
                                                  input logic [1:0]  m);
    logic [30+WORDWIDTH:0] seq;
    taps_t                 t;
    int unsigned           a;
    int unsigned           b;
    t   = prbs_taps(m);
    a   = 32'(t.a);
    b   = 32'(t.b);
    // seq is time-ordered: [30:0] known history, [30+W:31] new bits
    seq = {{WORDWIDTH{1'b0}}, h};
    for (int unsigned j = 0; j < WORDWIDTH; j++) begin
      seq[31 + j] = seq[31 + j - a] ^ seq[31 + j - b];
    end
    return seq[30+WORDWIDTH:31];
  endfunction

  always_comb begin
    next = unroll(history, mode);
  end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS7/15/23/31 word checker.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset (wins over dis)
//   dis         1 = freeze; only clearErr still acts
//   mode        0 PRBS7, 1 PRBS15, 2 PRBS23, 3 PRBS31
//   dinValid    din sampled when 1
//   din         received word, bit 0 earliest
//   clearErr    synchronous clear of errorCount (wins over increment)
//   locked      1 while in LOCKED
//   errorFlag   one-cycle pulse for a mismatching word while locked
//   errorCount  saturating error counter
// Build option: PRBS_CHK_BITCOUNT_EN -- count errored bits instead of
// errored words.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned WORDWIDTH        = 32,
  parameter int unsigned ERRCNT_WIDTH     = 16,
  parameter int unsigned LOCK_THRESHOLD   = 8,
  parameter int unsigned UNLOCK_THRESHOLD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dis,
  input  logic [1:0]              mode,
  input  logic                    dinValid,
  input  logic [WORDWIDTH-1:0]    din,
  input  logic                    clearErr,
  output logic                    locked,
  output logic                    errorFlag,
  output logic [ERRCNT_WIDTH-1:0] errorCount
);

  localparam int unsigned SUMW = ERRCNT_WIDTH + 8;

  state_t                  state, state_nxt;
  logic [30:0]             history, history_nxt;
  logic [1:0]              mode_q;
  logic [7:0]              search_cnt, search_cnt_nxt;
  logic [7:0]              good_cnt, good_cnt_nxt;
  logic [7:0]              bad_cnt, bad_cnt_nxt;
  logic [7:0]              search_need;
  logic [WORDWIDTH-1:0]    predicted;
  logic [WORDWIDTH-1:0]    diff;
  logic                    mismatch;
  logic [SUMW-1:0]         incr;
  logic [SUMW-1:0]         sum;
  logic [ERRCNT_WIDTH-1:0] count_sat, count_nxt;
  logic                    flag_nxt;

  prbs_predict #(
    .WORDWIDTH(WORDWIDTH)
  ) u_predict (
    .history(history),
    .mode   (mode_q),
    .next   (predicted)
  );

  assign diff        = din ^ predicted;
  assign mismatch    = |diff;
  assign search_need = 8'(search_words(mode_q, WORDWIDTH));

`ifdef PRBS_CHK_BITCOUNT_EN
  assign incr = SUMW'($countones(diff));
`else
  assign incr = SUMW'(1);
`endif

  // Wide sum never wraps; any carry beyond the counter width clamps to all-ones.
  assign sum       = SUMW'(errorCount) + incr;
  assign count_sat = (sum[SUMW-1:ERRCNT_WIDTH] != '0) ? '1 : sum[ERRCNT_WIDTH-1:0];

  always_comb begin
    state_nxt      = state;
    history_nxt    = history;
    search_cnt_nxt = search_cnt;
    good_cnt_nxt   = good_cnt;
    bad_cnt_nxt    = bad_cnt;
    flag_nxt       = errorFlag;
    count_nxt      = errorCount;

    if (!dis) begin
      flag_nxt = 1'b0;
      if (mode != mode_q) begin
        // Word sampled with a new mode is discarded; search restarts.
        state_nxt      = SEARCH;
        search_cnt_nxt = '0;
        good_cnt_nxt   = '0;
        bad_cnt_nxt    = '0;
      end else if (dinValid) begin
        case (state)
          SEARCH: begin
            history_nxt = 31'({din, history} >> WORDWIDTH);
            if (search_cnt + 8'd1 == search_need) begin
              state_nxt      = VERIFY;
              search_cnt_nxt = '0;
              good_cnt_nxt   = '0;
            end else begin
              search_cnt_nxt = search_cnt + 8'd1;
            end
          end
          VERIFY: begin
            history_nxt = 31'({din, history} >> WORDWIDTH);
            if (!mismatch) begin
              if (good_cnt + 8'd1 == 8'(LOCK_THRESHOLD)) begin
                state_nxt    = LOCKED;
                good_cnt_nxt = '0;
                bad_cnt_nxt  = '0;
              end else begin
                good_cnt_nxt = good_cnt + 8'd1;
              end
            end else begin
              state_nxt      = SEARCH;
              search_cnt_nxt = '0;
              good_cnt_nxt   = '0;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so a bit error is not re-seeded.
            history_nxt = 31'({predicted, history} >> WORDWIDTH);
            if (mismatch) begin
              flag_nxt  = 1'b1;
              count_nxt = count_sat;
              if (bad_cnt + 8'd1 == 8'(UNLOCK_THRESHOLD)) begin
                state_nxt      = SEARCH;
                search_cnt_nxt = '0;
                bad_cnt_nxt    = '0;
              end else begin
                bad_cnt_nxt = bad_cnt + 8'd1;
              end
            end else begin
              bad_cnt_nxt = '0;
            end
          end
          default: begin
            state_nxt      = SEARCH;
            search_cnt_nxt = '0;
            good_cnt_nxt   = '0;
            bad_cnt_nxt    = '0;
          end
        endcase
      end
    end

    if (clearErr) begin
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SEARCH;
      history    <= '0;
      mode_q     <= mode;
      search_cnt <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      locked     <= 1'b0;
      errorFlag  <= 1'b0;
      errorCount <= '0;
    end else begin
      state      <= state_nxt;
      history    <= history_nxt;
      mode_q     <= dis ? mode_q : mode;
      search_cnt <= search_cnt_nxt;
      good_cnt   <= good_cnt_nxt;
      bad_cnt    <= bad_cnt_nxt;
      locked     <= (state_nxt == LOCKED);
      errorFlag  <= flag_nxt;
      errorCount <= count_nxt;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: two checker instances (32-bit/16-bit count and
// 8-bit/4-bit count) against a bit-queue reference model, plus scripted
// lock/error/unlock/mode/saturation/reset/dis scenarios and a random phase.
module tb_prbs_checker;

  localparam int     WW   [2] = '{32, 8};
  localparam longint CMAX [2] = '{65535, 15};
  localparam int     LT = 8;
  localparam int     UT = 4;

  logic        clk = 1'b0;
  logic        rst_n  [2];
  logic        dis_s  [2];
  logic [1:0]  mode_s [2];
  logic        dv     [2];
  logic        clr    [2];
  logic [63:0] din_s  [2];
  logic        lk     [2];
  logic        ef     [2];
  logic [15:0] ec0;
  logic [3:0]  ec1;

  int n_cmp = 0;
  int n_bad = 0;

  // generator state (stream source), kept apart from the checker model
  logic [30:0] g_h [2];
  logic [1:0]  g_m [2];

  // checker reference model
  int          m_st [2];  // 0 search, 1 verify, 2 locked
  int          m_sc [2];
  int          m_gc [2];
  int          m_bc [2];
  logic [30:0] m_h  [2];
  logic [1:0]  m_mq [2];
  longint      m_cnt [2];
  bit          m_flag [2];

  prbs_checker #(
    .WORDWIDTH(32), .ERRCNT_WIDTH(16), .LOCK_THRESHOLD(LT), .UNLOCK_THRESHOLD(UT)
  ) u_dut32 (
    .clk(clk), .reset(rst_n[0]), .dis(dis_s[0]), .mode(mode_s[0]),
    .dinValid(dv[0]), .din(din_s[0][31:0]), .clearErr(clr[0]),
    .locked(lk[0]), .errorFlag(ef[0]), .errorCount(ec0)
  );

  prbs_checker #(
    .WORDWIDTH(8), .ERRCNT_WIDTH(4), .LOCK_THRESHOLD(LT), .UNLOCK_THRESHOLD(UT)
  ) u_dut8 (
    .clk(clk), .reset(rst_n[1]), .dis(dis_s[1]), .mode(mode_s[1]),
    .dinValid(dv[1]), .din(din_s[1][7:0]), .clearErr(clr[1]),
    .locked(lk[1]), .errorFlag(ef[1]), .errorCount(ec1)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int tap(input logic [1:0] m, input bit second);
    case (m)
      2'd0:    return second ? 6  : 7;
      2'd1:    return second ? 14 : 15;
      2'd2:    return second ? 18 : 23;
      default: return second ? 28 : 31;
    endcase
  endfunction

  function automatic logic [63:0] mask(input int i);
    return (64'd1 << WW[i]) - 64'd1;
  endfunction

  // h[k]: k=0 oldest .. 30 newest. Extends the stream by w bits.
  function automatic void prbs_words(input logic [30:0] h, input logic [1:0] m, input int w,
                                     output logic [63:0] word, output logic [30:0] h_out);
    bit q[$];
    int a;
    int b;
    a = tap(m, 1'b0);
    b = tap(m, 1'b1);
    for (int k = 0; k < 31; k++) q.push_back(h[k]);
    word = '0;
    for (int j = 0; j < w; j++) begin
      bit nb;
      nb = q[q.size() - a] ^ q[q.size() - b];
      q.push_back(nb);
      word[j] = nb;
    end
    for (int k = 0; k < 31; k++) h_out[k] = q[q.size() - 31 + k];
  endfunction

  function automatic logic [30:0] absorb(input logic [30:0] h, input logic [63:0] word, input int w);
    bit q[$];
    logic [30:0] r;
    for (int k = 0; k < 31; k++) q.push_back(h[k]);
    for (int j = 0; j < w; j++) q.push_back(word[j]);
    for (int k = 0; k < 31; k++) r[k] = q[q.size() - 31 + k];
    return r;
  endfunction

  task automatic model_step(input int i);
    logic [63:0] p;
    logic [63:0] d;
    logic [30:0] hp;
    longint      inc;
    int          need;
    if (!rst_n[i]) begin
      m_st[i] = 0; m_sc[i] = 0; m_gc[i] = 0; m_bc[i] = 0;
      m_h[i] = '0; m_mq[i] = mode_s[i]; m_cnt[i] = 0; m_flag[i] = 0;
    end else begin
      if (!dis_s[i]) begin
        m_flag[i] = 0;
        if (mode_s[i] != m_mq[i]) begin
          m_st[i] = 0; m_sc[i] = 0; m_gc[i] = 0; m_bc[i] = 0;
          m_mq[i] = mode_s[i];
        end else if (dv[i]) begin
          prbs_words(m_h[i], m_mq[i], WW[i], p, hp);
          d    = din_s[i] & mask(i);
          need = (tap(m_mq[i], 1'b0) + WW[i] - 1) / WW[i];
`ifdef PRBS_CHK_BITCOUNT_EN
          inc = $countones(d ^ p);
`else
          inc = 1;
`endif
          if (m_st[i] == 0) begin
            m_h[i] = absorb(m_h[i], d, WW[i]);
            m_sc[i]++;
            if (m_sc[i] == need) begin m_st[i] = 1; m_sc[i] = 0; m_gc[i] = 0; end
          end else if (m_st[i] == 1) begin
            m_h[i] = absorb(m_h[i], d, WW[i]);
            if (d == p) begin
              m_gc[i]++;
              if (m_gc[i] == LT) begin m_st[i] = 2; m_bc[i] = 0; end
            end else begin
              m_st[i] = 0; m_sc[i] = 0; m_gc[i] = 0;
            end
          end else begin
            m_h[i] = hp;
            if (d != p) begin
              m_flag[i] = 1;
              m_cnt[i]  = (m_cnt[i] + inc > CMAX[i]) ? CMAX[i] : m_cnt[i] + inc;
              m_bc[i]++;
              if (m_bc[i] == UT) begin m_st[i] = 0; m_sc[i] = 0; m_bc[i] = 0; end
            end else begin
              m_bc[i] = 0;
            end
          end
        end
      end
      if (clr[i]) m_cnt[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  always @(negedge clk) begin
    check("u32.locked",     64'(lk[0]), 64'(m_st[0] == 2));
    check("u32.errorFlag",  64'(ef[0]), 64'(m_flag[0]));
    check("u32.errorCount", 64'(ec0),   64'(m_cnt[0]));
    check("u8.locked",      64'(lk[1]), 64'(m_st[1] == 2));
    check("u8.errorFlag",   64'(ef[1]), 64'(m_flag[1]));
    check("u8.errorCount",  64'(ec1),   64'(m_cnt[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      dv[i]  = 1'b0;
      clr[i] = 1'b0;
    end
  endtask

  task automatic send(input int i, input logic [63:0] flip, input bit zero);
    logic [63:0] w;
    logic [30:0] hn;
    prbs_words(g_h[i], g_m[i], WW[i], w, hn);
    g_h[i]   = hn;
    din_s[i] = zero ? 64'd0 : ((w ^ flip) & mask(i));
    dv[i]    = 1'b1;
  endtask

  task automatic good_words(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      send(i, 64'd0, 1'b0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; dis_s[i] = 1'b0; dv[i] = 1'b0; clr[i] = 1'b0;
      din_s[i] = '0; g_h[i] = '1;
    end
    mode_s[0] = 2'd0; g_m[0] = 2'd0;
    mode_s[1] = 2'd3; g_m[1] = 2'd3;
    repeat (3) tick();
    check("rst.locked32", 64'(lk[0]), 64'd0);
    check("rst.flag32",   64'(ef[0]), 64'd0);
    check("rst.count32",  64'(ec0),   64'd0);
    check("rst.locked8",  64'(lk[1]), 64'd0);
    check("rst.count8",   64'(ec1),   64'd0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // 32-bit PRBS7 lock: 1 search word + 8 verify words
    send(0, 64'd0, 1'b0);
    check("gen.first_word", din_s[0], 64'h4F143040);
    tick();
    good_words(0, 7);
    check("lock32.before", 64'(lk[0]), 64'd0);
    good_words(0, 1);
    check("lock32.at9", 64'(lk[0]), 64'd1);
    good_words(0, 10000);
    check("lock32.count10k", 64'(ec0), 64'd0);
    check("lock32.still", 64'(lk[0]), 64'd1);

    // single bit error
    send(0, 64'h20, 1'b0);
    tick();
    check("err1.flag", 64'(ef[0]), 64'd1);
    check("err1.count", 64'(ec0), 64'd1);
    good_words(0, 1);
    check("err1.flag_drop", 64'(ef[0]), 64'd0);
    good_words(0, 50);
    check("err1.count_hold", 64'(ec0), 64'd1);
    check("err1.locked", 64'(lk[0]), 64'd1);

    // loss of lock on 4 zero words, then relock
    for (int k = 1; k <= 4; k++) begin
      send(0, 64'd0, 1'b1);
      tick();
      if (k == 3) check("unlock.at3", 64'(lk[0]), 64'd1);
    end
    check("unlock.at4", 64'(lk[0]), 64'd0);
    good_words(0, 8);
    check("relock.before", 64'(lk[0]), 64'd0);
    good_words(0, 1);
    check("relock.at9", 64'(lk[0]), 64'd1);

    // dis freezes, clearErr still acts
    dis_s[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din_s[0] = {$urandom, $urandom} & mask(0);
      dv[0] = 1'b1;
      tick();
    end
    check("dis.locked", 64'(lk[0]), 64'd1);
    clr[0] = 1'b1;
    tick();
    check("dis.clear", 64'(ec0), 64'd0);
    dis_s[0] = 1'b0;

    // reset while locked (with dis high) after an error
    send(0, 64'h1, 1'b0);
    tick();
    check("prerst.flag", 64'(ef[0]), 64'd1);
    rst_n[0] = 1'b0;
    dis_s[0] = 1'b1;
    din_s[0] = {$urandom, $urandom} & mask(0);
    dv[0] = 1'b1;
    tick();
    check("rstlk.locked", 64'(lk[0]), 64'd0);
    check("rstlk.flag",   64'(ef[0]), 64'd0);
    check("rstlk.count",  64'(ec0),   64'd0);
    rst_n[0] = 1'b1;
    dis_s[0] = 1'b0;

    // 8-bit PRBS31: 4 search words + 8 verify words
    good_words(1, 11);
    check("lock8.before", 64'(lk[1]), 64'd0);
    good_words(1, 1);
    check("lock8.at12", 64'(lk[1]), 64'd1);
    mode_s[1] = 2'd1;
    g_m[1] = 2'd1;
    tick();
    check("mode.unlock", 64'(lk[1]), 64'd0);
    good_words(1, 9);
    check("mode.before", 64'(lk[1]), 64'd0);
    good_words(1, 1);
    check("mode.relock", 64'(lk[1]), 64'd1);

    // saturation of the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      send(1, 64'h49, 1'b0);
      tick();
      good_words(1, 1);
    end
    check("sat.count", 64'(ec1), 64'hF);
    check("sat.locked", 64'(lk[1]), 64'd1);
    send(1, 64'h49, 1'b0);
    clr[1] = 1'b1;
    tick();
    check("clr.count", 64'(ec1), 64'd0);
    check("clr.flag", 64'(ef[1]), 64'd1);

    // random phase, both instances
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst_n[i] = ($urandom_range(0, 999) != 0);
        dis_s[i] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 399) == 0) begin
          mode_s[i] = 2'($urandom_range(0, 3));
          g_m[i] = mode_s[i];
        end
        if ($urandom_range(0, 3) != 0) begin
          if (dis_s[i]) begin
            din_s[i] = {$urandom, $urandom} & mask(i);
            dv[i] = 1'b1;
          end else begin
            send(i, ($urandom_range(0, 19) == 0) ? (64'd1 << $urandom_range(0, WW[i] - 1)) : 64'd0, 1'b0);
          end
        end
        clr[i] = ($urandom_range(0, 63) == 0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b1;
      dis_s[i] = 1'b0;
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
